// File: rtl/bus_xfer_ctrl.sv
// Bus master sequencer for the R1..R3 / 16x4 RAM shared-bus datapath (MOVE and SWAP macro).
// Define BUS_XFER_CNT_EN to add the xfer_cnt output counting completed transfers.
module bus_xfer_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int STROBE_TICKS = 1
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              ce,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [1:0]        cmd_src,
  input  logic [1:0]        cmd_dst,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic [1:0]        bus_sel,
  output logic [2:0]        ld_n,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef BUS_XFER_CNT_EN
  ,
  output logic [7:0]        xfer_cnt
`endif
);

  localparam logic       OP_SWAP     = 1'b1;
  localparam logic [1:0] SEL_RAM     = 2'd3;
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_HOLD    = 3'd3,
    S_ILLEGAL = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              state_r;
  logic                op_r;
  logic [1:0]          p_r;
  logic [1:0]          q_r;
  logic [1:0]          step_r;
  logic [ADDR_W-1:0]   base_r;
  logic [3:0]          tick_r;
  logic [1:0]          cur_dst_s;
  logic [1:0]          next_step_s;
  logic                last_step_s;
`ifdef BUS_XFER_CNT_EN
  logic [7:0]          xfer_cnt_r;
  assign xfer_cnt = xfer_cnt_r;
`endif

  function automatic logic is_illegal(input logic op, input logic [1:0] src, input logic [1:0] dst);
    logic bad;
    if (op == OP_SWAP) begin
      bad = (src == dst) || (src == SEL_RAM) || (dst == SEL_RAM);
    end else begin
      bad = (src == dst);
    end
    return bad;
  endfunction

  // SWAP: P->RAM[A], Q->RAM[A+1], RAM[A]->Q, RAM[A+1]->P; MOVE uses step 0 only.
  function automatic logic [1:0] step_sel(input logic op, input logic [1:0] step,
                                          input logic [1:0] p, input logic [1:0] q);
    logic [1:0] sel;
    if (op == OP_SWAP) begin
      case (step)
        2'd0:    sel = p;
        2'd1:    sel = q;
        default: sel = SEL_RAM;
      endcase
    end else begin
      sel = p;
    end
    return sel;
  endfunction

  function automatic logic [1:0] step_dst(input logic op, input logic [1:0] step,
                                          input logic [1:0] p, input logic [1:0] q);
    logic [1:0] dst;
    if (op == OP_SWAP) begin
      case (step)
        2'd0:    dst = SEL_RAM;
        2'd1:    dst = SEL_RAM;
        2'd2:    dst = q;
        default: dst = p;
      endcase
    end else begin
      dst = q;
    end
    return dst;
  endfunction

  function automatic logic [ADDR_W-1:0] step_addr(input logic op, input logic [1:0] step,
                                                  input logic [ADDR_W-1:0] base);
    return base + ADDR_W'(op & step[0]);
  endfunction

  function automatic logic [2:0] ld_decode(input logic [1:0] dst);
    logic [2:0] ld;
    case (dst)
      2'd0:    ld = 3'b110;
      2'd1:    ld = 3'b101;
      2'd2:    ld = 3'b011;
      default: ld = 3'b111;
    endcase
    return ld;
  endfunction

  assign cur_dst_s   = step_dst(op_r, step_r, p_r, q_r);
  assign next_step_s = step_r + 2'd1;
  assign last_step_s = (op_r != OP_SWAP) || (step_r == 2'd3);

  // Transfer sequencer with all control outputs registered.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r   <= S_IDLE;
      op_r      <= 1'b0;
      p_r       <= 2'd0;
      q_r       <= 2'd0;
      step_r    <= 2'd0;
      base_r    <= {ADDR_W{1'b0}};
      tick_r    <= 4'd0;
      bus_sel   <= 2'd0;
      ld_n      <= 3'b111;
      ram_we    <= 1'b0;
      ram_addr  <= {ADDR_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
`ifdef BUS_XFER_CNT_EN
      xfer_cnt_r <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r      <= cmd_op;
            p_r       <= cmd_src;
            q_r       <= cmd_dst;
            base_r    <= cmd_addr;
            step_r    <= 2'd0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (is_illegal(cmd_op, cmd_src, cmd_dst)) begin
              state_r <= S_ILLEGAL;
            end else begin
              state_r  <= S_SETUP;
              bus_sel  <= step_sel(cmd_op, 2'd0, cmd_src, cmd_dst);
              ram_addr <= step_addr(cmd_op, 2'd0, cmd_addr);
            end
          end
        end
        S_ILLEGAL: begin
          if (ce) begin
            state_r <= S_DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        S_SETUP: begin
          if (ce) begin
            state_r <= S_STROBE;
            tick_r  <= STROBE_LAST;
            ld_n    <= ld_decode(cur_dst_s);
            ram_we  <= (cur_dst_s == SEL_RAM);
          end
        end
        S_STROBE: begin
          if (ce) begin
            if (tick_r == 4'd0) begin
              state_r <= S_HOLD;
              ld_n    <= 3'b111;
              ram_we  <= 1'b0;
`ifdef BUS_XFER_CNT_EN
              xfer_cnt_r <= xfer_cnt_r + 8'd1;
`endif
            end else begin
              tick_r <= tick_r - 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (ce) begin
            if (last_step_s) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              // Read data for RAM-source steps settles during SETUP, before the strobe.
              state_r  <= S_SETUP;
              step_r   <= next_step_s;
              bus_sel  <= step_sel(op_r, next_step_s, p_r, q_r);
              ram_addr <= step_addr(op_r, next_step_s, base_r);
            end
          end
        end
        S_DONE: begin
          state_r   <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state_r   <= S_IDLE;
          ld_n      <= 3'b111;
          ram_we    <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with a behavioural R1..R3 / RAM datapath model.
module tb_bus_xfer_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ce, cmd_valid, cmd_valid2, cmd_op;
  logic [1:0] cmd_src, cmd_dst;
  logic [3:0] cmd_addr;
  logic       cmd_ready, ram_we, busy, done, err;
  logic [1:0] bus_sel;
  logic [2:0] ld_n;
  logic [3:0] ram_addr;
  logic       cmd_ready2, ram_we2, busy2, done2, err2;
  logic [1:0] bus_sel2;
  logic [2:0] ld_n2;
  logic [3:0] ram_addr2;
`ifdef BUS_XFER_CNT_EN
  logic [7:0] xfer_cnt, xfer_cnt2, cnt0;
`endif

  bus_xfer_ctrl #(.ADDR_W(4), .STROBE_TICKS(1)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .ce(ce), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_addr(cmd_addr),
    .bus_sel(bus_sel), .ld_n(ld_n), .ram_we(ram_we), .ram_addr(ram_addr),
    .busy(busy), .done(done), .err(err)
`ifdef BUS_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  bus_xfer_ctrl #(.ADDR_W(4), .STROBE_TICKS(2)) dut2 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .ce(ce), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_addr(cmd_addr),
    .bus_sel(bus_sel2), .ld_n(ld_n2), .ram_we(ram_we2), .ram_addr(ram_addr2),
    .busy(busy2), .done(done2), .err(err2)
`ifdef BUS_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt2)
`endif
  );

  // Datapath model: 74377 registers and RAM capture the bus on the clock edge.
  logic [3:0] r_m [3];
  logic [3:0] ram_m [16];
  logic [3:0] bus_m;
  logic       preload;

  always_comb begin
    case (bus_sel)
      2'd0:    bus_m = r_m[0];
      2'd1:    bus_m = r_m[1];
      2'd2:    bus_m = r_m[2];
      default: bus_m = ram_m[ram_addr];
    endcase
  end

  always @(posedge clk) begin
    if (preload) begin
      r_m[0] <= 4'h3;
      r_m[1] <= 4'hA;
      r_m[2] <= 4'h5;
      for (int i = 0; i < 16; i++) ram_m[i] <= 4'h0;
    end else begin
      for (int i = 0; i < 3; i++) if (!ld_n[i]) r_m[i] <= bus_m;
      if (ram_we) ram_m[ram_addr] <= bus_m;
    end
  end

  int viol = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (!$onehot0(~ld_n) || (ld_n != 3'b111 && ram_we) ||
          !$onehot0(~ld_n2) || (ld_n2 != 3'b111 && ram_we2))
        viol <= viol + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] addr, output int lat, output int strobes,
                         output logic err_seen);
    @(negedge clk);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_addr = addr; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = ~op; cmd_src = ~src; cmd_dst = ~dst; cmd_addr = ~addr;
    lat = 1; strobes = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (ld_n != 3'b111 || ram_we) strobes++;
      @(negedge clk);
      lat++;
    end
    err_seen = err;
  endtask

  typedef struct {
    logic        op;
    logic [1:0]  src;
    logic [1:0]  dst;
    logic [3:0]  addr;
    logic        exp_err;
    int          exp_strobes;
    int          exp_lat;
    int          exp_xfers;
    logic [11:0] exp_regs;   // {R3, R2, R1}
    logic [3:0]  chk_addr;
    logic [3:0]  exp_ram;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, strobes, n, chg_viol, ready_viol;
    logic err_seen, ce_was;
    logic [9:0] snap, cur;

    // Model starts with R1=3, R2=A, R3=5, RAM all zero.
    vecs[0] = '{1'b1, 2'd1, 2'd2, 4'd15, 1'b0, 4, 13, 4, 12'hA53, 4'd15, 4'hA};
    vecs[1] = '{1'b0, 2'd1, 2'd2, 4'd0,  1'b0, 1, 4,  1, 12'h553, 4'd0,  4'h5};
    vecs[2] = '{1'b0, 2'd0, 2'd3, 4'd7,  1'b0, 1, 4,  1, 12'h553, 4'd7,  4'h3};
    vecs[3] = '{1'b0, 2'd3, 2'd0, 4'd15, 1'b0, 1, 4,  1, 12'h55A, 4'd15, 4'hA};
    vecs[4] = '{1'b0, 2'd2, 2'd2, 4'd1,  1'b1, 0, 2,  0, 12'h55A, 4'd7,  4'h3};
    vecs[5] = '{1'b0, 2'd3, 2'd3, 4'd4,  1'b1, 0, 2,  0, 12'h55A, 4'd4,  4'h0};
    vecs[6] = '{1'b1, 2'd0, 2'd3, 4'd2,  1'b1, 0, 2,  0, 12'h55A, 4'd0,  4'h5};
    vecs[7] = '{1'b1, 2'd2, 2'd2, 4'd5,  1'b1, 0, 2,  0, 12'h55A, 4'd15, 4'hA};
    vecs[8] = '{1'b1, 2'd0, 2'd2, 4'd3,  1'b0, 4, 13, 4, 12'hA55, 4'd4,  4'h5};
    vecs[9] = '{1'b0, 2'd2, 2'd0, 4'd0,  1'b0, 1, 4,  1, 12'hA5A, 4'd3,  4'hA};

    rst_n = 1'b0; ce = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_op = 1'b0; cmd_src = 2'd0; cmd_dst = 2'd0; cmd_addr = 4'd0; preload = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus_sel, ld_n, ram_we, ram_addr, busy, done, err, cmd_ready},
          {2'd0, 3'b111, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    check("reset_outputs2", {bus_sel2, ld_n2, ram_we2, ram_addr2, busy2, done2, err2, cmd_ready2},
          {2'd0, 3'b111, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    preload = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
`ifdef BUS_XFER_CNT_EN
      cnt0 = xfer_cnt;
`endif
      run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].addr, lat, strobes, err_seen);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_err", i), {31'd0, err_seen}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_strobes", i), strobes, vecs[i].exp_strobes);
      @(negedge clk);
      check($sformatf("v%0d_after_done", i), {done, busy, cmd_ready}, 3'b001);
      check($sformatf("v%0d_regs", i), {r_m[2], r_m[1], r_m[0]}, vecs[i].exp_regs);
      check($sformatf("v%0d_ram", i), ram_m[vecs[i].chk_addr], vecs[i].exp_ram);
`ifdef BUS_XFER_CNT_EN
      check($sformatf("v%0d_xfer_cnt", i), 8'(xfer_cnt - cnt0), vecs[i].exp_xfers);
`endif
    end

    // STROBE_TICKS=2 instance: MOVE R1->RAM[5].
    @(negedge clk);
    cmd_op = 1'b0; cmd_src = 2'd0; cmd_dst = 2'd3; cmd_addr = 4'd5; cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("st2_clk%0d", k), {bus_sel2, ram_addr2, ram_we2, ld_n2},
            {2'd0, 4'd5, (k == 2 || k == 3), 3'b111});
      @(negedge clk);
    end
    check("st2_done", {done2, err2}, 2'b10);
    @(negedge clk);
    check("st2_idle", {done2, busy2, cmd_ready2}, 3'b001);
`ifdef BUS_XFER_CNT_EN
    check("st2_xfer_cnt", xfer_cnt2, 8'd1);
`endif

    // ce pulsed 1-in-4; cmd_valid stays high with a different command while busy.
    @(negedge clk);
    cmd_op = 1'b0; cmd_src = 2'd2; cmd_dst = 2'd1; cmd_addr = 4'd6; cmd_valid = 1'b1; ce = 1'b0;
    @(negedge clk);
    cmd_src = 2'd3; cmd_dst = 2'd0; cmd_addr = 4'd9;
    check("ce_accept", {busy, cmd_ready, bus_sel, ram_addr}, {1'b1, 1'b0, 2'd2, 4'd6});
    snap = {bus_sel, ld_n, ram_we, ram_addr};
    chg_viol = 0; ready_viol = 0; n = 0;
    while (done !== 1'b1 && n < 200) begin
      ce = (n % 4 == 3);
      ce_was = ce;
      @(negedge clk);
      n++;
      cur = {bus_sel, ld_n, ram_we, ram_addr};
      if (cur != snap && !ce_was) chg_viol++;
      if (done !== 1'b1 && cmd_ready) ready_viol++;
      snap = cur;
    end
    cmd_valid = 1'b0; ce = 1'b1;
    check("ce_done_err", {done, err}, 2'b10);
    check("ce_latency", n, 12);
    check("ce_hold_outputs", chg_viol, 0);
    check("ce_not_ready_busy", ready_viol, 0);
    @(negedge clk);
    check("ce_regs", {r_m[2], r_m[1], r_m[0]}, 12'hAAA);
    check("ce_idle", {busy, cmd_ready}, 2'b01);

    // Reset dropped during the first strobe of a SWAP.
    @(negedge clk);
    cmd_op = 1'b1; cmd_src = 2'd0; cmd_dst = 2'd1; cmd_addr = 4'd8; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (ram_we !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_strobe_seen", ram_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {ld_n, ram_we, busy, cmd_ready, done}, {3'b111, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
`ifdef BUS_XFER_CNT_EN
    check("rst_xfer_cnt", xfer_cnt, 8'd0);
`endif
    run_cmd(1'b0, 2'd3, 2'd1, 4'd4, lat, strobes, err_seen);
    check("post_rst_latency", lat, 4);
    check("post_rst_err", {31'd0, err_seen}, 32'd0);
    @(negedge clk);
    check("post_rst_regs", {r_m[2], r_m[1], r_m[0]}, 12'hA5A);
    check("rst_aborted_write", ram_m[8], 4'h0);
`ifdef BUS_XFER_CNT_EN
    check("post_rst_xfer_cnt", xfer_cnt, 8'd1);
`endif

    check("strobe_exclusive", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Bus master sequencer for the 4-bit shared-bus datapath: three 74377-style registers (R1..R3) and a 16x4 RAM, joined by a source mux.
- Accepts transfer commands and drives the control lines automatically: source-mux select, active-low register load enables, RAM write enable and RAM address.
- Replaces the hand-operated switch sequence for register/RAM moves.
- Also executes a 4-transfer SWAP macro, which exchanges two registers through two RAM cells.

Parameters:
- ADDR_W, 4: RAM address width; addresses wrap modulo 2**ADDR_W.
- STROBE_TICKS, 1: number of ce ticks the load/write strobe stays asserted (range 1..15).

Ports:
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- ce  in  1  step enable from the clock divider; all sequencing advances only on cycles where ce=1.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  1  0=MOVE, 1=SWAP.
- cmd_src  in  2  code 0=R1, 1=R2, 2=R3, 3=RAM.
- cmd_dst  in  2  same encoding as cmd_src.
- cmd_addr  in  ADDR_W  RAM address (MOVE), or base address A (SWAP).
- bus_sel  out  2  source-mux select, same encoding as cmd_src.
- ld_n  out  3  active-low load enables; bit0=R1, bit1=R2, bit2=R3.
- ram_we  out  1  RAM write strobe, active-high.
- ram_addr  out  ADDR_W  RAM address.
- busy  out  1  command in progress.
- done  out  1  one-clock pulse when a command finishes.
- err  out  1  valid only with done; set when the command was illegal.

Behaviour:
- Reset (asynchronous, active-low) forces: state IDLE, bus_sel=0, ld_n=3'b111, ram_we=0, ram_addr=0, busy=0, done=0, err=0, cmd_ready=1.
  - Reset asserted mid-transfer aborts immediately; any strobe in flight drops in the same instant.
- cmd_ready = (state==IDLE). A command is accepted on any clock where cmd_valid&&cmd_ready, regardless of ce.
  - busy=1 from the clock after acceptance until done is pulsed.
- Command fields are latched at acceptance; later input changes are ignored.
- Per-transfer FSM, with every step gated by ce:
  - SETUP: drive bus_sel and ram_addr; all strobes inactive; lasts 1 tick.
  - STROBE: assert ld_n[dst]=0, or ram_we=1 when dst=RAM; lasts STROBE_TICKS ticks; bus_sel and ram_addr held.
  - HOLD: strobes released; bus_sel and ram_addr held; lasts 1 tick.
  - After HOLD: go to the next transfer, or to DONE.
- DONE: done=1 and err valid for exactly one clock, then IDLE.
- All outputs are registered. At most one ld_n bit is low at any time, and ld_n and ram_we are never active together.
- MOVE is one transfer src->dst.
  - src==dst, or src=RAM with dst=RAM, is illegal: no strobe is issued; go directly to DONE with err=1 on the next ce tick.
- SWAP(src=P, dst=Q, addr=A) is four transfers in this order:
  - P->RAM[A]
  - Q->RAM[A+1]
  - RAM[A]->Q
  - RAM[A+1]->P
- SWAP address rules:
  - A+1 wraps, so A=15 uses address 0.
  - For RAM-source transfers, bus_sel=3 and ram_addr is set during SETUP, so read data is stable before STROBE.
- SWAP with P==Q, or with either P or Q equal to RAM, is illegal: err=1 and no strobes.
- With ce held at 0, the FSM freezes and all outputs hold their values.
- Timing: MOVE latency from acceptance to done is 2+STROBE_TICKS ce ticks plus one clock. SWAP takes four times that many ticks.

Optional Feature:
- Macro BUS_XFER_CNT_EN.
- When defined: adds output port xfer_cnt [7:0].
  - Counts completed strobes, i.e. successful transfers; a SWAP adds 4.
  - Wraps 255->0.
  - Reset to 0 by CPU_RESETN.
  - Illegal commands do not increment it.
- When undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- ce=1 constantly; MOVE src=1 dst=2 -> bus_sel=1 for 3 clocks; ld_n=3'b011 for exactly 1 clock (the middle one); done pulses with err=0; busy low after done.
- MOVE src=0 dst=3 addr=5, STROBE_TICKS=2 -> ram_addr=5 and bus_sel=0 held for 4 clocks; ram_we=1 on clocks 2-3 only; ld_n stays 3'b111.
- SWAP P=1 Q=2 A=15, with a behavioural register/RAM model preloaded R2=4'hA, R3=4'h5 -> afterwards R2=5, R3=A, RAM[15]=A, RAM[0]=5; done pulses once; xfer_cnt +4 when BUS_XFER_CNT_EN is defined.
- MOVE src=2 dst=2, then MOVE src=3 dst=3 -> each gives done with err=1; no strobe asserted; xfer_cnt unchanged.
- ce pulsed 1-in-4 during a MOVE -> outputs change only on ce cycles; cmd_valid held high while busy is not accepted (cmd_ready=0).
- CPU_RESETN dropped during STROBE of a SWAP -> ld_n=3'b111, ram_we=0, busy=0 asynchronously; after release cmd_ready=1 and a new MOVE executes normally.
